// File: rtl/systolic_pkg.sv
// Shared types for the systolic array host driver.
package systolic_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    READ  = 2'd3
  } systolic_drv_state_t;

endpackage

// File: rtl/systolic_vec_buf.sv
// size x nbits register file written one element at a time by index,
// with a synchronous clear and the whole vector exposed flat.
module systolic_vec_buf #(
  parameter int unsigned size  = 4,
  parameter int unsigned nbits = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       we,
  input  logic [$clog2(size)-1:0]    idx,
  input  logic [nbits-1:0]           din,
  output logic [size*nbits-1:0]      vec
);

  localparam int unsigned iw = $clog2(size);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
    end else if (clear) begin
      vec <= '0;
    end else if (we) begin
      for (int unsigned j = 0; j < size; j++) begin
        if (idx == iw'(j)) vec[j*nbits +: nbits] <= din;
      end
    end
  end

endmodule

// File: rtl/systolic_driver.sv
// Host-side driver for the systolic MAC array: assembles serial job data into
// X/W vectors, hands them to the array, waits for drain, then streams results out.
module systolic_driver
  import systolic_pkg::*;
#(
  parameter int unsigned size         = 4,
  parameter int unsigned nbits        = 16,
  parameter int unsigned drain_cycles = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [nbits-1:0]          in_msg,
  input  logic                      in_val,
  output logic                      in_rdy,
  output logic [size*nbits-1:0]     l_x_col_out,
  output logic                      x_send_val,
  input  logic                      x_send_rdy,
  output logic [size*nbits-1:0]     t_w_row_out,
  output logic                      w_send_val,
  input  logic                      w_send_rdy,
  output logic [$clog2(size)-1:0]   out_rsel,
  output logic [$clog2(size)-1:0]   out_csel,
  input  logic [nbits-1:0]          b_s_in,
  output logic [nbits-1:0]          out_msg,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic                      job_done
);

  localparam int unsigned iw = $clog2(size);
  localparam int unsigned ew = $clog2(2*size);
  localparam int unsigned dw = $clog2(drain_cycles+1);

  systolic_drv_state_t state;
  logic [ew-1:0] elem;
  logic [iw-1:0] step;
  logic [dw-1:0] dcnt;
  logic [iw-1:0] row;
  logic [iw-1:0] col;
  logic          x_sent;
  logic          w_sent;

  logic accept;
  logic x_we;
  logic w_we;
  logic x_fire;
  logic w_fire;
  logic out_fire;
  logic last_rc;

  // All handshake outputs decode directly from registered state.
  assign in_rdy     = (state == LOAD);
  assign accept     = in_rdy && in_val;
  assign x_we       = accept && !elem[ew-1];
  assign w_we       = accept &&  elem[ew-1];

  assign x_send_val = (state == SEND) && !x_sent;
  assign w_send_val = (state == SEND) && !w_sent;
  assign x_fire     = x_send_val && x_send_rdy;
  assign w_fire     = w_send_val && w_send_rdy;

  assign out_val    = (state == READ);
  assign out_msg    = b_s_in;
  assign out_rsel   = row;
  assign out_csel   = col;
  assign out_fire   = out_val && out_rdy;
  assign last_rc    = (row == iw'(size-1)) && (col == iw'(size-1));
  assign job_done   = out_fire && last_rc;

  // Upper element-counter bit selects X vs W; low bits are the vector index.
  systolic_vec_buf #(.size(size), .nbits(nbits)) u_x_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (job_done),
    .we    (x_we),
    .idx   (elem[iw-1:0]),
    .din   (in_msg),
    .vec   (l_x_col_out)
  );

  systolic_vec_buf #(.size(size), .nbits(nbits)) u_w_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (job_done),
    .we    (w_we),
    .idx   (elem[iw-1:0]),
    .din   (in_msg),
    .vec   (t_w_row_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      elem   <= '0;
      step   <= '0;
      dcnt   <= '0;
      row    <= '0;
      col    <= '0;
      x_sent <= 1'b0;
      w_sent <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (elem == ew'(2*size-1)) begin
              elem  <= '0;
              state <= SEND;
            end else begin
              elem <= elem + ew'(1);
            end
          end
        end

        // Channels complete independently; leave once both have fired.
        SEND: begin
          if ((x_sent || x_fire) && (w_sent || w_fire)) begin
            x_sent <= 1'b0;
            w_sent <= 1'b0;
            if (step == iw'(size-1)) begin
              state <= DRAIN;
            end else begin
              step  <= step + iw'(1);
              state <= LOAD;
            end
          end else begin
            x_sent <= x_sent || x_fire;
            w_sent <= w_sent || w_fire;
          end
        end

        DRAIN: begin
          if (dcnt == dw'(drain_cycles-1)) begin
            dcnt  <= '0;
            state <= READ;
          end else begin
            dcnt <= dcnt + dw'(1);
          end
        end

        READ: begin
          if (out_fire) begin
            if (col == iw'(size-1)) begin
              col <= '0;
              if (row == iw'(size-1)) begin
                row   <= '0;
                step  <= '0;
                state <= LOAD;
              end else begin
                row <= row + iw'(1);
              end
            end else begin
              col <= col + iw'(1);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_driver.sv
// Directed self-checking bench for systolic_driver with size=2, nbits=16, drain_cycles=6.
module tb_systolic_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_msg = '0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [31:0] l_x_col_out;
  logic        x_send_val;
  logic        x_send_rdy = 1'b1;
  logic [31:0] t_w_row_out;
  logic        w_send_val;
  logic        w_send_rdy = 1'b1;
  logic        out_rsel;
  logic        out_csel;
  logic [15:0] b_s_in;
  logic [15:0] out_msg;
  logic        out_val;
  logic        out_rdy = 1'b0;
  logic        job_done;

  int passed = 0;
  int total  = 0;

  systolic_driver #(.size(2), .nbits(16), .drain_cycles(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_msg      (in_msg),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .l_x_col_out (l_x_col_out),
    .x_send_val  (x_send_val),
    .x_send_rdy  (x_send_rdy),
    .t_w_row_out (t_w_row_out),
    .w_send_val  (w_send_val),
    .w_send_rdy  (w_send_rdy),
    .out_rsel    (out_rsel),
    .out_csel    (out_csel),
    .b_s_in      (b_s_in),
    .out_msg     (out_msg),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .job_done    (job_done)
  );

  always #5 clk = ~clk;

  // Array result model: (r,c) -> 10 + 2r + c
  assign b_s_in = 16'd10 + {14'd0, out_rsel, 1'b0} + {15'd0, out_csel};

  task automatic push(input logic [15:0] v);
    @(negedge clk);
    in_val = 1'b1;
    in_msg = v;
  endtask

  // Second step of a job with filler data, then read out everything.
  task automatic finish_job(output logic seen);
    push(16'd0); push(16'd0); push(16'd0); push(16'd0);
    @(negedge clk);
    in_val = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (job_done === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++; if (in_rdy !== 1'b1) $display("FAIL rst_in_rdy: got %b expected 1", in_rdy); else passed++;
    total++; if ({x_send_val, w_send_val, out_val, job_done} !== 4'b0)
      $display("FAIL rst_valids: got %b expected 0000", {x_send_val, w_send_val, out_val, job_done}); else passed++;
    total++; if ({out_rsel, out_csel} !== 2'b00) $display("FAIL rst_sel: got %b expected 00", {out_rsel, out_csel}); else passed++;
    total++; if (l_x_col_out !== 32'd0 || t_w_row_out !== 32'd0)
      $display("FAIL rst_bufs: got %h/%h expected 0/0", l_x_col_out, t_w_row_out); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_send();
    x_send_rdy = 1'b1; w_send_rdy = 1'b1; out_rdy = 1'b0;
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    @(negedge clk); in_val = 1'b0; #1;
    total++; if ({x_send_val, w_send_val, in_rdy} !== 3'b110)
      $display("FAIL s0_vals: got %b expected 110", {x_send_val, w_send_val, in_rdy}); else passed++;
    total++; if (l_x_col_out !== {16'd2, 16'd1}) $display("FAIL s0_xvec: got %h expected 00020001", l_x_col_out); else passed++;
    total++; if (t_w_row_out !== {16'd4, 16'd3}) $display("FAIL s0_wvec: got %h expected 00040003", t_w_row_out); else passed++;
    @(negedge clk); #1;
    total++; if ({x_send_val, w_send_val, in_rdy} !== 3'b001)
      $display("FAIL s0_one_cycle: got %b expected 001", {x_send_val, w_send_val, in_rdy}); else passed++;
    push(16'd5); push(16'd6); push(16'd7); push(16'd8);
    @(negedge clk); in_val = 1'b0; #1;
    total++; if (l_x_col_out !== {16'd6, 16'd5}) $display("FAIL s1_xvec: got %h expected 00060005", l_x_col_out); else passed++;
    total++; if (t_w_row_out !== {16'd8, 16'd7}) $display("FAIL s1_wvec: got %h expected 00080007", t_w_row_out); else passed++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      total++; if ({out_val, x_send_val, w_send_val} !== 3'b000)
        $display("FAIL drain_idle%0d: got %b expected 000", i, {out_val, x_send_val, w_send_val}); else passed++;
    end
    @(negedge clk); #1;
    total++; if ({out_val, out_rsel, out_csel} !== 3'b100)
      $display("FAIL drain_read: got %b expected 100", {out_val, out_rsel, out_csel}); else passed++;
  endtask

  task automatic test_read_stall();
    int   e;
    logic tog;
    e = 0; tog = 1'b1;
    for (int i = 0; i < 12 && e < 4; i++) begin
      if (i > 0) @(negedge clk);
      out_rdy = tog; #1;
      total++; if (out_val !== 1'b1 || out_msg !== 16'(10 + e))
        $display("FAIL read_msg%0d: got val=%b msg=%0d expected val=1 msg=%0d", i, out_val, out_msg, 10 + e); else passed++;
      total++; if (job_done !== (tog && e == 3))
        $display("FAIL read_done%0d: got %b expected %b", i, job_done, (tog && e == 3)); else passed++;
      if (tog) e++;
      tog = !tog;
    end
    total++; if (e != 4) $display("FAIL read_count: got %0d expected 4", e); else passed++;
    @(negedge clk); #1;
    total++; if ({out_val, job_done, in_rdy} !== 3'b001)
      $display("FAIL read_back_load: got %b expected 001", {out_val, job_done, in_rdy}); else passed++;
  endtask

  task automatic test_w_stall();
    logic seen;
    out_rdy = 1'b1; x_send_rdy = 1'b1; w_send_rdy = 1'b0;
    push(16'd51); push(16'd52); push(16'd53); push(16'd54);
    @(negedge clk); in_val = 1'b0; #1;
    total++; if ({x_send_val, w_send_val} !== 2'b11)
      $display("FAIL ws_first: got %b expected 11", {x_send_val, w_send_val}); else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++; if ({x_send_val, w_send_val} !== 2'b01 || t_w_row_out !== {16'd54, 16'd53})
        $display("FAIL ws_hold%0d: got %b %h expected 01 00360035", i, {x_send_val, w_send_val}, t_w_row_out); else passed++;
    end
    @(negedge clk); w_send_rdy = 1'b1; #1;
    total++; if ({x_send_val, w_send_val} !== 2'b01 || t_w_row_out !== {16'd54, 16'd53})
      $display("FAIL ws_fire: got %b %h expected 01 00360035", {x_send_val, w_send_val}, t_w_row_out); else passed++;
    @(negedge clk); #1;
    total++; if ({x_send_val, w_send_val, in_rdy} !== 3'b001)
      $display("FAIL ws_done: got %b expected 001", {x_send_val, w_send_val, in_rdy}); else passed++;
    finish_job(seen);
    total++; if (seen !== 1'b1) $display("FAIL ws_job_done: got %b expected 1", seen); else passed++;
  endtask

  task automatic test_reset_mid_load();
    logic seen;
    push(16'd61); push(16'd62); push(16'd63);
    @(negedge clk); in_val = 1'b0; #1;
    total++; if (l_x_col_out !== {16'd62, 16'd61}) $display("FAIL rm_pre: got %h expected 003e003d", l_x_col_out); else passed++;
    rst = 1'b1; #1;
    total++; if (l_x_col_out !== 32'd0 || t_w_row_out !== 32'd0)
      $display("FAIL rm_bufs: got %h/%h expected 0/0", l_x_col_out, t_w_row_out); else passed++;
    total++; if ({in_rdy, x_send_val, w_send_val, out_val, job_done} !== 5'b10000)
      $display("FAIL rm_ctrl: got %b expected 10000", {in_rdy, x_send_val, w_send_val, out_val, job_done}); else passed++;
    @(negedge clk); rst = 1'b0;
    push(16'd21); push(16'd22); push(16'd23); push(16'd24);
    @(negedge clk); in_val = 1'b0; #1;
    total++; if (l_x_col_out !== {16'd22, 16'd21} || t_w_row_out !== {16'd24, 16'd23})
      $display("FAIL rm_vecs: got %h/%h expected 00160015/00180017", l_x_col_out, t_w_row_out); else passed++;
    total++; if ({x_send_val, w_send_val} !== 2'b11)
      $display("FAIL rm_vals: got %b expected 11", {x_send_val, w_send_val}); else passed++;
    finish_job(seen);
    total++; if (seen !== 1'b1) $display("FAIL rm_job_done: got %b expected 1", seen); else passed++;
  endtask

  task automatic test_in_val_hold();
    logic seen;
    out_rdy = 1'b1; x_send_rdy = 1'b1; w_send_rdy = 1'b1;
    push(16'd31); push(16'd32); push(16'd33); push(16'd34);
    @(negedge clk); in_msg = 16'd99; #1;
    total++; if (in_rdy !== 1'b0 || l_x_col_out !== {16'd32, 16'd31} || t_w_row_out !== {16'd34, 16'd33})
      $display("FAIL ih_s0: got rdy=%b %h/%h expected rdy=0 0020001f/00220021", in_rdy, l_x_col_out, t_w_row_out); else passed++;
    push(16'd35); push(16'd36); push(16'd37); push(16'd38);
    @(negedge clk); in_msg = 16'd99; #1;
    total++; if (l_x_col_out !== {16'd36, 16'd35} || t_w_row_out !== {16'd38, 16'd37})
      $display("FAIL ih_s1: got %h/%h expected 00240023/00260025", l_x_col_out, t_w_row_out); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (job_done === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) $display("FAIL ih_job_done: got %b expected 1", seen); else passed++;
    push(16'd41); push(16'd42); push(16'd43); push(16'd44);
    @(negedge clk); in_msg = 16'd99; #1;
    total++; if ({x_send_val, w_send_val} !== 2'b11 || l_x_col_out !== {16'd42, 16'd41} || t_w_row_out !== {16'd44, 16'd43})
      $display("FAIL ih_job2: got %b %h/%h expected 11 002a0029/002c002b", {x_send_val, w_send_val}, l_x_col_out, t_w_row_out); else passed++;
    in_val = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_send();
    test_drain();
    test_read_stall();
    test_w_stall();
    test_reset_mid_load();
    test_in_val_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
